mem_access_stage: RTL

Memory-access stage of the pipelined CPU, between the EX/MEM register and the MEM/WB register. It drives the data RAM's single address port, returns load data or the pass-through ALU result to writeback, and holds stores in a one-entry store buffer. Stores retire to RAM in cycles where no load needs the port. Loads that hit the buffered address are forwarded.

---
 rtl/mem_access_stage_if.sv | 49 ++++
 rtl/mem_access_stage.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: bundles the three buses of the memory-access stage.
//   in_*   : EX/MEM side (valid/ready handshake plus decoded load/store info)
//   ram_*  : single-port data RAM (combinational read data)
//   out_*  : MEM/WB side (valid/ready handshake plus writeback fields)
//   sb_empty : store buffer idle indication for halt/fence logic
// master : the environment (pipeline upstream, RAM, writeback)
// slave  : the memory-access stage itself
interface mem_access_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned REG_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              in_read;
  logic              in_write;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [REG_W-1:0]  in_dest;
  logic              in_regwrite;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_dest;
  logic              out_regwrite;

  logic              sb_empty;

  modport master (
    output in_valid, in_read, in_write, in_addr, in_wdata, in_dest, in_regwrite,
    output ram_rdata, out_ready,
    input  in_ready, ram_addr, ram_read, ram_write, ram_wdata,
    input  out_valid, out_result, out_dest, out_regwrite, sb_empty
  );

  modport slave (
    input  in_valid, in_read, in_write, in_addr, in_wdata, in_dest, in_regwrite,
    input  ram_rdata, out_ready,
    output in_ready, ram_addr, ram_read, ram_write, ram_wdata,
    output out_valid, out_result, out_dest, out_regwrite, sb_empty
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Drives the single data RAM port, returns load data (or the ALU result for
// non-loads) to writeback, and keeps a one-entry store buffer that retires
// to RAM whenever no load needs the port. Loads hitting the buffered
// address are forwarded from the buffer.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : mem_access_stage_if.slave (in_*, ram_*, out_*, sb_empty)
module mem_access_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_stage_if.slave bus
);

  logic              sb_valid_q, sb_valid_d;
  logic [ADDR_W-1:0] sb_addr_q,  sb_addr_d;
  logic [DATA_W-1:0] sb_data_q,  sb_data_d;

  logic              out_valid_q,    out_valid_d;
  logic [DATA_W-1:0] out_result_q,   out_result_d;
  logic [REG_W-1:0]  out_dest_q,     out_dest_d;
  logic              out_regwrite_q, out_regwrite_d;

  logic              in_ready;
  logic              fire;
  logic              is_load;
  logic              is_store;
  logic              load_fire;
  logic              drain;
  logic [DATA_W-1:0] result;

  // A load+store encoding is treated as a load; the store half is dropped.
  assign is_load   = bus.in_read;
  assign is_store  = bus.in_write && !bus.in_read;
  assign in_ready  = !out_valid_q || bus.out_ready;
  assign fire      = bus.in_valid && in_ready && rst_n;
  assign load_fire = fire && is_load;
  // rst_n gate keeps a store pending at reset from ever reaching the RAM.
  assign drain     = sb_valid_q && !load_fire && rst_n;

  assign bus.in_ready     = in_ready;
  assign bus.ram_read     = load_fire;
  assign bus.ram_write    = drain;
  assign bus.ram_addr     = load_fire ? bus.in_addr : sb_addr_q;
  assign bus.ram_wdata    = sb_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_dest     = out_dest_q;
  assign bus.out_regwrite = out_regwrite_q;
  assign bus.sb_empty     = !sb_valid_q;

  always_comb begin
    result = DATA_W'(bus.in_addr);
    if (is_load) begin
      if (sb_valid_q && (sb_addr_q == bus.in_addr)) begin
        result = sb_data_q;
      end else begin
        result = bus.ram_rdata;
      end
    end
  end

  always_comb begin
    sb_valid_d     = sb_valid_q;
    sb_addr_d      = sb_addr_q;
    sb_data_d      = sb_data_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_dest_d     = out_dest_q;
    out_regwrite_d = out_regwrite_q;

    if (drain) begin
      sb_valid_d = 1'b0;
    end
    // A store capture overrides the drain clear: the old entry leaves via
    // the free port while the new one takes its place.
    if (fire && is_store) begin
      sb_valid_d = 1'b1;
      sb_addr_d  = bus.in_addr;
      sb_data_d  = bus.in_wdata;
    end

    if (fire) begin
      out_valid_d    = 1'b1;
      out_result_d   = result;
      out_dest_d     = bus.in_dest;
      out_regwrite_d = bus.in_regwrite && !is_store;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_valid_q     <= 1'b0;
      sb_addr_q      <= '0;
      sb_data_q      <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_dest_q     <= '0;
      out_regwrite_q <= 1'b0;
    end else begin
      sb_valid_q     <= sb_valid_d;
      sb_addr_q      <= sb_addr_d;
      sb_data_q      <= sb_data_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_dest_q     <= out_dest_d;
      out_regwrite_q <= out_regwrite_d;
    end
  end

endmodule
